// File: rtl/fir_transposed.sv
`default_nettype none
// ============================================================================
//  Module      : fir_transposed
//  Description : Parametrised transposed-form FIR filter. Streaming samples
//                qualified by a valid strobe. Coefficients are written into
//                a shadow bank and committed atomically to the active bank.
//                Arithmetic is signed fixed point Q1.(DATA_WIDTH-1).
//
//  Build option: FIR_SATURATE_EN - when defined, products and adders clamp
//                instead of wrapping, and the o_ovf port is present.
//
//  Ports       : i_clk          rising-edge clock
//                i_rst_n        synchronous active-low reset
//                i_valid/iv_din input sample and its qualifier
//                i_flush        clear delay line and output (coefs kept)
//                i_coef_we      write iv_coef_data to shadow[iv_coef_addr]
//                i_coef_commit  copy shadow bank into active bank
//                o_valid/ov_dout filter output and its qualifier
//                o_ovf          clamp event for this output (saturate build)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_transposed #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_TAPS   = 8,
   parameter int ADDR_WIDTH = $clog2(NUM_TAPS)
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_valid,
   input  logic signed [DATA_WIDTH-1:0] iv_din,
   input  logic                         i_flush,
   input  logic                         i_coef_we,
   input  logic        [ADDR_WIDTH-1:0] iv_coef_addr,
   input  logic signed [DATA_WIDTH-1:0] iv_coef_data,
   input  logic                         i_coef_commit,
   output logic                         o_valid,
   output logic signed [DATA_WIDTH-1:0] ov_dout
`ifdef FIR_SATURATE_EN
   ,
   output logic                         o_ovf
`endif
);

   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam logic signed [DATA_WIDTH-1:0] C_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] C_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Product rescaled to Q1.(DATA_WIDTH-1); returns {overflow, result}.
   function automatic logic [DATA_WIDTH:0] f_mul(input logic signed [DATA_WIDTH-1:0] a,
                                                input logic signed [DATA_WIDTH-1:0] b);
      logic signed [PROD_W-1:0] full;
      logic signed [PROD_W-1:0] shifted;
      logic                     ovf;
      logic [DATA_WIDTH-1:0]    res;
      full    = PROD_W'(a) * PROD_W'(b);
      shifted = full >>> (DATA_WIDTH - 1);
      // Result fits only if every bit above the kept field matches its sign.
      ovf     = (shifted[PROD_W-1:DATA_WIDTH-1] != {(DATA_WIDTH+1){shifted[DATA_WIDTH-1]}});
      res     = shifted[DATA_WIDTH-1:0];
`ifdef FIR_SATURATE_EN
      if (ovf) res = shifted[PROD_W-1] ? C_MIN : C_MAX;
`endif
      return {ovf, res};
   endfunction

   // One-bit-wider add; returns {overflow, result}.
   function automatic logic [DATA_WIDTH:0] f_add(input logic signed [DATA_WIDTH-1:0] a,
                                                input logic signed [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH:0]   sum;
      logic                  ovf;
      logic [DATA_WIDTH-1:0] res;
      sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
      ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
      res = sum[DATA_WIDTH-1:0];
`ifdef FIR_SATURATE_EN
      if (ovf) res = sum[DATA_WIDTH] ? C_MIN : C_MAX;
`endif
      return {ovf, res};
   endfunction

   logic signed [DATA_WIDTH-1:0] shadow_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] shadow_d [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] active_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] active_d [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
   logic                         v1_q, v1_d;
   logic signed [DATA_WIDTH-1:0] s_q [1:NUM_TAPS-1];
   logic signed [DATA_WIDTH-1:0] s_d [1:NUM_TAPS-1];
   logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                         valid_q, valid_d;

   logic signed [DATA_WIDTH-1:0] w_prod [NUM_TAPS];
   logic        [NUM_TAPS-1:0]   w_prod_ovf;
   logic signed [DATA_WIDTH-1:0] w_sum [NUM_TAPS-1];
   logic        [NUM_TAPS-2:0]   w_sum_ovf;

   generate
      for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
         logic [DATA_WIDTH:0] w_m;
         assign w_m           = f_mul(x1_q, active_q[k]);
         assign w_prod[k]     = w_m[DATA_WIDTH-1:0];
         assign w_prod_ovf[k] = w_m[DATA_WIDTH];
      end
      // Adder k combines tap k with the partial sum coming from tap k+1.
      for (genvar k = 0; k < NUM_TAPS - 1; k++) begin : g_add
         logic [DATA_WIDTH:0] w_a;
         assign w_a          = f_add(w_prod[k], s_q[k+1]);
         assign w_sum[k]     = w_a[DATA_WIDTH-1:0];
         assign w_sum_ovf[k] = w_a[DATA_WIDTH];
      end
   endgenerate

   // Coefficient banks. The commit copies shadow_d so a same-cycle write
   // lands in the active bank too. Out-of-range addresses match no entry.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      for (int k = 0; k < NUM_TAPS; k++) begin
         if (i_coef_we && (32'(iv_coef_addr) == k)) shadow_d[k] = iv_coef_data;
      end
      if (i_coef_commit) active_d = shadow_d;
   end

   // Datapath next state. Flush drops both the captured sample and the
   // sample arriving on the same edge.
   always_comb begin
      x1_d    = iv_din;
      v1_d    = i_valid & ~i_flush;
      s_d     = s_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (i_flush) begin
         for (int k = 1; k < NUM_TAPS; k++) s_d[k] = '0;
         dout_d = '0;
      end else if (v1_q) begin
         s_d[NUM_TAPS-1] = w_prod[NUM_TAPS-1];
         for (int k = 1; k < NUM_TAPS - 1; k++) s_d[k] = w_sum[k];
         dout_d  = w_sum[0];
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         x1_q    <= '0;
         v1_q    <= 1'b0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            shadow_q[k] <= '0;
            active_q[k] <= '0;
         end
         for (int k = 1; k < NUM_TAPS; k++) s_q[k] <= '0;
      end else begin
         x1_q     <= x1_d;
         v1_q     <= v1_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         s_q      <= s_d;
      end
   end

   assign o_valid = valid_q;
   assign ov_dout = dout_q;

`ifdef FIR_SATURATE_EN
   // Each partial sum carries a sticky clamp flag down the chain with it.
   logic [NUM_TAPS-1:1] sovf_q, sovf_d;
   logic                ovf_q, ovf_d;

   always_comb begin
      sovf_d = sovf_q;
      ovf_d  = 1'b0;
      if (i_flush) begin
         sovf_d = '0;
      end else if (v1_q) begin
         sovf_d[NUM_TAPS-1] = w_prod_ovf[NUM_TAPS-1];
         for (int k = 1; k < NUM_TAPS - 1; k++) begin
            sovf_d[k] = w_prod_ovf[k] | w_sum_ovf[k] | sovf_q[k+1];
         end
         ovf_d = w_prod_ovf[0] | w_sum_ovf[0] | sovf_q[1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sovf_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sovf_q <= sovf_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ^{w_prod_ovf, w_sum_ovf};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_transposed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_transposed
//  Description : Directed self-checking bench for fir_transposed
//                (DATA_WIDTH=16, NUM_TAPS=4, 3-bit coefficient address).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_transposed;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int AW = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                valid;
   logic signed [W-1:0] din;
   logic                flush;
   logic                coef_we;
   logic [AW-1:0]       coef_addr;
   logic signed [W-1:0] coef_data;
   logic                commit;
   logic                out_valid;
   logic signed [W-1:0] dout;
`ifdef FIR_SATURATE_EN
   logic                ovf;
`endif

   int checks   = 0;
   int failures = 0;

   logic signed [W-1:0] exp_imp  [5];
   logic signed [W-1:0] exp_new  [5];
   logic signed [W-1:0] exp_zero [5];
   logic signed [W-1:0] exp_ramp [5];

   fir_transposed #(
      .DATA_WIDTH (W),
      .NUM_TAPS   (N),
      .ADDR_WIDTH (AW)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (valid),
      .iv_din        (din),
      .i_flush       (flush),
      .i_coef_we     (coef_we),
      .iv_coef_addr  (coef_addr),
      .iv_coef_data  (coef_data),
      .i_coef_commit (commit),
      .o_valid       (out_valid),
      .ov_dout       (dout)
`ifdef FIR_SATURATE_EN
      ,
      .o_ovf         (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic [AW-1:0] a, input logic signed [W-1:0] d,
                             input logic do_commit);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      commit    = do_commit;
      tick();
      coef_we   = 1'b0;
      commit    = 1'b0;
   endtask

   task automatic load_bank(input logic signed [W-1:0] h0, input logic signed [W-1:0] h1,
                            input logic signed [W-1:0] h2, input logic signed [W-1:0] h3);
      write_coef(3'd0, h0, 1'b0);
      write_coef(3'd1, h1, 1'b0);
      write_coef(3'd2, h2, 1'b0);
      write_coef(3'd3, h3, 1'b0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic do_flush();
      valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Impulse of 0.5 followed by four zeros; expects e[] on consecutive outputs.
   task automatic run_impulse(input string tag, input logic signed [W-1:0] e [5]);
      valid = 1'b1;
      din   = 16'sd16384;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_latency o_valid=%0b expected 0", tag, out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         valid = (i < 4);
         din   = 16'sd0;
         tick();
         checks++;
         if (out_valid !== 1'b1 || dout !== e[i]) begin
            failures++;
            $display("FAIL %s_out%0d o_valid=%0b ov_dout=%0d expected o_valid=1 ov_dout=%0d",
                     tag, i, out_valid, dout, e[i]);
         end
      end
      valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_tail o_valid=%0b expected 0", tag, out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || dout !== 16'sd0) begin
         failures++;
         $display("FAIL reset o_valid=%0b ov_dout=%0d expected 0/0", out_valid, dout);
      end
`ifdef FIR_SATURATE_EN
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_ovf o_ovf=%0b expected 0", ovf);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_impulse();
      load_bank(16'sd16384, 16'sd8192, -16'sd16384, 16'sd4096);
      run_impulse("impulse", exp_imp);
   endtask

   task automatic test_gaps();
      do_flush();
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1;
         din   = (i == 0) ? 16'sd16384 : 16'sd0;
         tick();
         valid = 1'b0;
         din   = 16'sh1234;   // junk on invalid cycles must not enter the line
         tick();
         checks++;
         if (out_valid !== 1'b1 || dout !== exp_imp[i]) begin
            failures++;
            $display("FAIL gap_out%0d o_valid=%0b ov_dout=%0d expected 1/%0d",
                     i, out_valid, dout, exp_imp[i]);
         end
         for (int g = 0; g < 2; g++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || dout !== exp_imp[i]) begin
               failures++;
               $display("FAIL gap_hold%0d_%0d o_valid=%0b ov_dout=%0d expected 0/%0d",
                        i, g, out_valid, dout, exp_imp[i]);
            end
         end
      end
      din = 16'sd0;
   endtask

   task automatic test_double_buffer();
      do_flush();
      for (int a = 0; a < N; a++) write_coef(AW'(a), 16'sd32767, 1'b0);
      valid = 1'b1;
      din   = 16'sd16384;
      for (int t = 0; t < 6; t++) begin
         tick();
         if (t >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_ramp[t-1]) begin
               failures++;
               $display("FAIL shadow_ramp%0d o_valid=%0b ov_dout=%0d expected 1/%0d",
                        t - 1, out_valid, dout, exp_ramp[t-1]);
            end
         end
      end
      valid = 1'b0;
      din   = 16'sd0;
      tick();
      tick();
      write_coef(3'd5, 16'sd0, 1'b0);   // out of range: must not alias onto a tap
      write_coef(3'd0, 16'sd0, 1'b1);   // write-through into the commit
      do_flush();
      run_impulse("commit", exp_new);
   endtask

   task automatic test_overflow();
      logic signed [W-1:0] e_prod, e_sum;
`ifdef FIR_SATURATE_EN
      e_prod = 16'sd32767;
      e_sum  = 16'sd32767;
`else
      e_prod = 16'sh8000;
      e_sum  = -16'sd4;
`endif
      load_bank(16'sh8000, 16'sd0, 16'sd0, 16'sd0);
      do_flush();
      valid = 1'b1;
      din   = 16'sh8000;
      tick();
      valid = 1'b0;
      din   = 16'sd0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== e_prod) begin
         failures++;
         $display("FAIL ovf_product o_valid=%0b ov_dout=%0d expected 1/%0d", out_valid, dout, e_prod);
      end
`ifdef FIR_SATURATE_EN
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_product_flag o_ovf=%0b expected 1", ovf);
      end
`endif
      load_bank(16'sd32767, 16'sd32767, 16'sd0, 16'sd0);
      do_flush();
      valid = 1'b1;
      din   = 16'sd32767;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 16'sd32766) begin
         failures++;
         $display("FAIL ovf_sum_first o_valid=%0b ov_dout=%0d expected 1/32766", out_valid, dout);
      end
`ifdef FIR_SATURATE_EN
      checks++;
      if (ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_sum_first_flag o_ovf=%0b expected 0", ovf);
      end
`endif
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== e_sum) begin
         failures++;
         $display("FAIL ovf_sum o_valid=%0b ov_dout=%0d expected 1/%0d", out_valid, dout, e_sum);
      end
`ifdef FIR_SATURATE_EN
      checks++;
      if (ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sum_flag o_ovf=%0b expected 1", ovf);
      end
`endif
      valid = 1'b0;
      din   = 16'sd0;
      tick();
      tick();
   endtask

   task automatic test_flush_valid();
      load_bank(16'sd16384, 16'sd8192, -16'sd16384, 16'sd4096);
      do_flush();
      valid = 1'b1;
      din   = 16'sd16384;
      tick();
      tick();
      tick();
      flush = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || dout !== 16'sd0) begin
         failures++;
         $display("FAIL flush_edge o_valid=%0b ov_dout=%0d expected 0/0", out_valid, dout);
      end
      flush = 1'b0;
      valid = 1'b0;
      din   = 16'sd0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop o_valid=%0b expected 0", out_valid);
      end
      run_impulse("post_flush", exp_imp);
   endtask

   task automatic test_reset_mid();
      valid = 1'b1;
      din   = 16'sd16384;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || dout !== 16'sd0) begin
         failures++;
         $display("FAIL reset_mid o_valid=%0b ov_dout=%0d expected 0/0", out_valid, dout);
      end
      rst_n = 1'b1;
      valid = 1'b0;
      din   = 16'sd0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_inflight o_valid=%0b expected 0", out_valid);
      end
      run_impulse("post_reset", exp_zero);
   endtask

   initial begin
      exp_imp  = '{16'sd8192, 16'sd4096, -16'sd8192, 16'sd2048, 16'sd0};
      exp_new  = '{16'sd0, 16'sd16383, 16'sd16383, 16'sd16383, 16'sd0};
      exp_zero = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      exp_ramp = '{16'sd8192, 16'sd12288, 16'sd4096, 16'sd6144, 16'sd6144};
      rst_n     = 1'b0;
      valid     = 1'b0;
      din       = 16'sd0;
      flush     = 1'b0;
      coef_we   = 1'b0;
      coef_addr = 3'd0;
      coef_data = 16'sd0;
      commit    = 1'b0;

      test_reset();
      test_impulse();
      test_gaps();
      test_double_buffer();
      test_overflow();
      test_flush_valid();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
